// File: rtl/encoder_8x3_pending.sv
// encoder_8x3_pending
//   Sticky 8-to-3 priority encoder with a valid/ack handshake. It is the return path
//   of the 3x8 one-hot decoder: a rising edge on d(7-k) latches request code k into a
//   pending register. The FSM then presents one pending code at a time on s/valid
//   until the consumer acks it.
//   Code mapping is d7->0 ... d0->7, so encode(decode(s)) == s.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   enable    in   1: capture request edges and start presentations
//   d0..d7    in   request lines (0->1 transition = one request)
//   ack       in   consumer accepts s; ignored while valid=0
//   s         out  presented code (registered, frozen while valid=1)
//   valid     out  s holds a pending request awaiting ack
//   overflow  out  one-cycle pulse: request edge on a code already pending
module encoder_8x3_pending #(
    parameter bit PRIO_HIGH = 1'b1  // 1: code 7 (d0) wins, 0: code 0 (d7) wins
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       d4,
    input  logic       d5,
    input  logic       d6,
    input  logic       d7,
    input  logic       ack,
    output logic [2:0] s,
    output logic       valid,
    output logic       overflow
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [7:0] req;
    logic [7:0] edge_det;
    logic [7:0] clr_mask;
    logic [7:0] prev_q,    prev_d;
    logic [7:0] pending_q, pending_d;
    logic [0:0] state_q,   state_d;
    logic [2:0] s_q,       s_d;
    logic       ovf_q,     ovf_d;

    // Request vector in code order: req[k] corresponds to d(7-k).
    assign req      = {d0, d1, d2, d3, d4, d5, d6, d7};
    assign edge_det = req & ~prev_q;

    // Only the presented code can be cleared, and only on an accepted ack.
    assign clr_mask = (ack && state_q == PRESENT) ? (8'b1 << s_q) : 8'b0;

    function automatic logic [2:0] select(input logic [7:0] p);
        select = 3'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 8; i++)
                if (p[i]) select = i[2:0];
        end else begin
            for (int i = 7; i >= 0; i--)
                if (p[i]) select = i[2:0];
        end
    endfunction

    always_comb begin
        prev_d    = req;
        pending_d = pending_q & ~clr_mask;
        ovf_d     = 1'b0;
        state_d   = state_q;
        s_d       = s_q;

        // Applying the set after the clear makes a same-cycle edge on the acked code win.
        if (enable) begin
            pending_d = pending_d | edge_det;
            ovf_d     = |(edge_det & pending_q & ~clr_mask);
        end

        case (state_q)
            IDLE: begin
                // Uses the registered pending, so fresh captures wait one cycle.
                if (enable && pending_q != 8'b0) begin
                    s_d     = select(pending_q);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 8'b0;
            pending_q <= 8'b0;
            state_q   <= IDLE;
            s_q       <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
        end
    end

    assign s        = s_q;
    assign valid    = (state_q == PRESENT);
    assign overflow = ovf_q;

endmodule
